// File: rtl/pid_core_pkg.sv
// Shared definitions for the PID stage: FSM states, gain/error widths and
// the output clamp limits.
package pid_core_pkg;

  // Gain width; also the number of shift-add steps per product.
  localparam int CBITS   = 8;
  // Error e = sp - pv and its first difference de = e - e_prev.
  localparam int E_BITS  = 9;
  localparam int DE_BITS = 10;
  // Output clamp range of the 8-bit stimulus.
  localparam int OUT_MIN = 0;
  localparam int OUT_MAX = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_MUL_P = 3'd2,
    ST_MUL_I = 3'd3,
    ST_MUL_D = 3'd4,
    ST_OUT   = 3'd5
  } pid_state_e;

endpackage

// File: rtl/pid_core_mult_shift_add.sv
// Sequential shift-add multiplier: signed operand times unsigned CBITS-bit
// coefficient, one coefficient bit per cycle, LSB first. It does not own the
// accumulator: it adds its partial products into acc_in and hands the sum
// back on acc_out, which the caller registers whenever step is high.
// A one-cycle start launches a run of exactly CBITS steps; done is high
// during the last step.
module pid_core_mult_shift_add
  import pid_core_pkg::*;
#(
  parameter int ACCBITS = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [ACCBITS-1:0] operand,
  input  logic [CBITS-1:0]          coef,
  input  logic signed [ACCBITS-1:0] acc_in,
  output logic signed [ACCBITS-1:0] acc_out,
  output logic                      step,
  output logic                      done
);

  localparam int IW = $clog2(CBITS);

  logic          run;
  logic [IW-1:0] cnt;
  logic [IW-1:0] idx;

  // Current bit index and the partial-product add for this step.
  always_comb begin
    step    = start | run;
    idx     = start ? '0 : cnt;
    done    = step && (idx == IW'(CBITS - 1));
    acc_out = acc_in;
    if (step && coef[idx]) begin
      acc_out = acc_in + (operand <<< idx);
    end
  end

  // Bit counter; the run ends after the last coefficient bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (step) begin
      cnt <= idx + IW'(1);
      run <= !done;
    end
  end

endmodule

// File: rtl/pid_core.sv
// Discrete PID stage. Each accepted pv_stb runs one update:
// error/integrator/derivative, then kp*e + ki*integ + kd*de through one
// shared shift-add multiplier, then shift and clamp to an 8-bit stimulus.
//
// Handshake: pv_stb is a one-cycle strobe with sp/pv/gains valid in the same
// cycle. It is accepted only when the core is idle and no strobe is already
// pending; the inputs are captured on that edge and busy rises on the next.
// A strobe that is not accepted is dropped and reported by a one-cycle
// overrun pulse two edges later. done pulses for one cycle on the edge that
// updates stimulus, busy falls on that same edge, and a new strobe may be
// sampled on the following edge.
module pid_core
  import pid_core_pkg::*;
#(
  parameter int IBITS     = 12,
  parameter int ACCBITS   = 24,
  parameter int OUT_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pv_stb,
  input  logic [7:0]       sp,
  input  logic [7:0]       pv,
  input  logic [CBITS-1:0] kp,
  input  logic [CBITS-1:0] ki,
  input  logic [CBITS-1:0] kd,
  output logic [7:0]       stimulus,
  output logic             done,
  output logic             busy,
  output logic             overrun,
  output pid_state_e       state_dbg
);

  localparam logic signed [IBITS:0]     I_POS = (IBITS+1)'((1 << (IBITS - 1)) - 1);
  localparam logic signed [IBITS:0]     I_NEG = -I_POS;
  localparam logic signed [ACCBITS-1:0] Y_MAX = ACCBITS'(OUT_MAX);

  pid_state_e state;

  // Input stage: accepted strobe, dropped strobe, latched operands.
  logic             acc_ok;
  logic             stb_q;
  logic             ovr_q;
  logic [7:0]       sp_l;
  logic [7:0]       pv_l;
  logic [CBITS-1:0] kp_l;
  logic [CBITS-1:0] ki_l;
  logic [CBITS-1:0] kd_l;

  // Controller state carried between samples and within one computation.
  logic signed [E_BITS-1:0]  e_cur;
  logic signed [E_BITS-1:0]  e_prev;
  logic signed [DE_BITS-1:0] de_r;
  logic signed [IBITS-1:0]   integ;
  logic signed [ACCBITS-1:0] acc;
  logic                      mul_start;

  // Combinational next values.
  logic signed [E_BITS-1:0]  e_next;
  logic signed [DE_BITS-1:0] de_next;
  logic signed [IBITS:0]     isum;
  logic signed [IBITS-1:0]   integ_next;
  logic signed [ACCBITS-1:0] y;
  logic [7:0]                stim_next;

  // Multiplier interface.
  logic signed [ACCBITS-1:0] mul_operand;
  logic [CBITS-1:0]          mul_coef;
  logic signed [ACCBITS-1:0] mul_acc;
  logic                      mul_step;
  logic                      mul_done;

  assign state_dbg = state;
  assign acc_ok    = pv_stb && !busy && !stb_q;

  // Error, saturating integrator, derivative and output clamp.
  always_comb begin
    e_next  = $signed({1'b0, sp_l}) - $signed({1'b0, pv_l});
    de_next = DE_BITS'(e_next) - DE_BITS'(e_prev);
    isum    = (IBITS+1)'(integ) + (IBITS+1)'(e_next);
    if (isum > I_POS) begin
      integ_next = I_POS[IBITS-1:0];
    end else if (isum < I_NEG) begin
      integ_next = I_NEG[IBITS-1:0];
    end else begin
      integ_next = isum[IBITS-1:0];
    end
    y = acc >>> OUT_SHIFT;
    if (y[ACCBITS-1]) begin
      stim_next = 8'(OUT_MIN);
    end else if (y > Y_MAX) begin
      stim_next = 8'(OUT_MAX);
    end else begin
      stim_next = y[7:0];
    end
  end

  // Route the term being multiplied to the shared multiplier.
  always_comb begin
    mul_operand = '0;
    mul_coef    = '0;
    case (state)
      ST_MUL_P: begin
        mul_operand = ACCBITS'(e_cur);
        mul_coef    = kp_l;
      end
      ST_MUL_I: begin
        mul_operand = ACCBITS'(integ);
        mul_coef    = ki_l;
      end
      ST_MUL_D: begin
        mul_operand = ACCBITS'(de_r);
        mul_coef    = kd_l;
      end
      default: ;
    endcase
  end

  pid_core_mult_shift_add #(
    .ACCBITS(ACCBITS)
  ) u_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .operand(mul_operand),
    .coef   (mul_coef),
    .acc_in (acc),
    .acc_out(mul_acc),
    .step   (mul_step),
    .done   (mul_done)
  );

  // Strobe intake, sequencing FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      stb_q     <= 1'b0;
      ovr_q     <= 1'b0;
      sp_l      <= '0;
      pv_l      <= '0;
      kp_l      <= '0;
      ki_l      <= '0;
      kd_l      <= '0;
      e_cur     <= '0;
      e_prev    <= '0;
      de_r      <= '0;
      integ     <= '0;
      acc       <= '0;
      mul_start <= 1'b0;
      stimulus  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      mul_start <= 1'b0;
      stb_q     <= acc_ok;
      ovr_q     <= pv_stb && !acc_ok;
      overrun   <= ovr_q;
      if (acc_ok) begin
        sp_l <= sp;
        pv_l <= pv;
        kp_l <= kp;
        ki_l <= ki;
        kd_l <= kd;
      end
      if (mul_step) begin
        acc <= mul_acc;
      end
      case (state)
        ST_IDLE: begin
          if (stb_q) begin
            busy  <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          e_cur     <= e_next;
          e_prev    <= e_next;
          de_r      <= de_next;
          integ     <= integ_next;
          acc       <= '0;
          mul_start <= 1'b1;
          state     <= ST_MUL_P;
        end
        ST_MUL_P: begin
          if (mul_done) begin
            mul_start <= 1'b1;
            state     <= ST_MUL_I;
          end
        end
        ST_MUL_I: begin
          if (mul_done) begin
            mul_start <= 1'b1;
            state     <= ST_MUL_D;
          end
        end
        ST_MUL_D: begin
          if (mul_done) begin
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          stimulus <= stim_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_core.sv
// Bench for pid_core: directed scenarios plus randomized samples, each
// checked against a sample-level PID model (integer arithmetic on e, integ,
// de) with an expected-stimulus queue.
module tb_pid_core;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    pv_stb;
  logic [7:0]              sp, pv, kp, ki, kd;
  logic [7:0]              stimulus;
  logic                    done, busy, overrun;
  pid_core_pkg::pid_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_integ = 0;
  int m_eprev = 0;
  logic [7:0] exp_q[$];

  pid_core #(
    .IBITS(12),
    .ACCBITS(24),
    .OUT_SHIFT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pv_stb   (pv_stb),
    .sp       (sp),
    .pv       (pv),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .stimulus (stimulus),
    .done     (done),
    .busy     (busy),
    .overrun  (overrun),
    .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One PID sample from the rules: e, clamped integrator, derivative,
  // weighted sum, floor divide by 16, clamp to 0..255.
  function automatic int model_step(input int s, input int p, input int gp,
                                    input int gi, input int gd);
    int e, de, sum, yv;
    e = s - p;
    m_integ = m_integ + e;
    if (m_integ > 2047)  m_integ = 2047;
    if (m_integ < -2047) m_integ = -2047;
    de = e - m_eprev;
    m_eprev = e;
    sum = gp * e + gi * m_integ + gd * de;
    yv = sum >>> 4;
    if (yv < 0)   return 0;
    if (yv > 255) return 255;
    return yv;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    pv_stb = 1'b0;
    m_integ = 0;
    m_eprev = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_inputs(input int s, input int p, input int gp,
                              input int gi, input int gd);
    sp = 8'(s);
    pv = 8'(p);
    kp = 8'(gp);
    ki = 8'(gi);
    kd = 8'(gd);
  endtask

  task automatic scramble_inputs();
    sp = 8'($urandom);
    pv = 8'($urandom);
    kp = 8'($urandom);
    ki = 8'($urandom);
    kd = 8'($urandom);
  endtask

  // Strobe one sample, scramble inputs while busy, wait for done and score.
  task automatic run_sample(input string tag, input int s, input int p,
                            input int gp, input int gi, input int gd);
    int lat;
    logic [7:0] e_stim;
    exp_q.push_back(8'(model_step(s, p, gp, gi, gd)));
    @(negedge clk);
    drive_inputs(s, p, gp, gi, gd);
    pv_stb = 1'b1;
    @(posedge clk);
    #1;
    pv_stb = 1'b0;
    scramble_inputs();
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    e_stim = exp_q.pop_front();
    check_eq({tag, "_latency"}, lat, 27);
    check_eq({tag, "_stimulus"}, int'(stimulus), int'(e_stim));
  endtask

  initial begin
    int done_cnt;
    logic [7:0] e_stim;

    // Reset values.
    reset  = 1'b1;
    pv_stb = 1'b0;
    drive_inputs(0, 0, 0, 0, 0);
    #12;
    check_eq("rst_stimulus", int'(stimulus), 0);
    check_eq("rst_done",     int'(done), 0);
    check_eq("rst_busy",     int'(busy), 0);
    check_eq("rst_overrun",  int'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;

    // P only.
    run_sample("p_only", 100, 60, 16, 0, 0);

    // Asynchronous reset in the middle of the integral product.
    @(negedge clk);
    drive_inputs(200, 10, 50, 40, 30);
    pv_stb = 1'b1;
    @(posedge clk);
    #1;
    pv_stb = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_stimulus", int'(stimulus), 0);
    check_eq("midrst_busy",     int'(busy), 0);
    check_eq("midrst_done",     int'(done), 0);
    check_eq("midrst_state",    int'(state_dbg), int'(pid_core_pkg::ST_IDLE));
    m_integ = 0;
    m_eprev = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check_eq("midrst_no_done", done_cnt, 0);
    run_sample("after_rst", 200, 10, 50, 40, 30);

    // Integrator accumulation, saturation and unwinding from the clamp.
    do_reset();
    run_sample("i_acc1", 10, 0, 0, 16, 0);
    run_sample("i_acc2", 10, 0, 0, 16, 0);
    run_sample("i_acc3", 10, 0, 0, 16, 0);
    for (int k = 0; k < 9; k++) run_sample("i_wind", 255, 0, 0, 16, 0);
    run_sample("i_hold", 0, 0, 0, 16, 0);
    run_sample("i_unwind", 0, 255, 0, 1, 0);

    // Output clamp at both ends.
    run_sample("clamp_low",  0, 255, 255, 0, 0);
    run_sample("clamp_high", 255, 0, 255, 0, 0);

    // Derivative kick, steady error, then error reversal.
    do_reset();
    run_sample("d_first",  50, 0, 0, 0, 16);
    run_sample("d_steady", 50, 0, 0, 0, 16);
    run_sample("d_neg",    50, 60, 0, 0, 16);

    // Zero gains give zero output.
    run_sample("zero_gain", 200, 20, 0, 0, 0);

    // Overrun: second strobe at edge 5 is dropped.
    exp_q.push_back(8'(model_step(120, 40, 20, 3, 7)));
    @(negedge clk);
    drive_inputs(120, 40, 20, 3, 7);
    pv_stb = 1'b1;
    @(posedge clk);
    #1;
    pv_stb = 1'b0;
    scramble_inputs();
    for (int n = 1; n <= 27; n++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("ovr_busy_e%0d", n),    int'(busy),    int'(n <= 26));
      check_eq($sformatf("ovr_overrun_e%0d", n), int'(overrun), int'(n == 6));
      check_eq($sformatf("ovr_done_e%0d", n),    int'(done),    int'(n == 27));
      if (n == 4) begin
        drive_inputs(5, 250, 255, 255, 255);
        pv_stb = 1'b1;
      end
      if (n == 5) pv_stb = 1'b0;
    end
    e_stim = exp_q.pop_front();
    check_eq("ovr_stimulus", int'(stimulus), int'(e_stim));
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check_eq("ovr_single_done", done_cnt, 0);

    // Randomized samples, sometimes with a gain forced to zero.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      int rs, rp, g0, g1, g2;
      rs = $urandom_range(0, 255);
      rp = $urandom_range(0, 255);
      g0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      g1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 40);
      g2 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      run_sample($sformatf("rand%0d", k), rs, rp, g0, g1, g2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
